axi_slave_ram: RTL



---
 rtl/axi_slave_ram.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_ram.sv
// AXI3/AXI4 slave RAM endpoint: one write burst and one read burst in flight at a time,
// word-addressed array with byte strobes, protocol errors answered with SLVERR.
module axi_slave_ram #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_AW     = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [31:0]           s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [ID_WIDTH-1:0]   s_axi_wid,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic                  s_axi_wlast,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [31:0]           s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic unused_bits;
  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, s_axi_wid,
                         s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

  // Holds the ready outputs low until the first edge after reset releases.
  logic live;
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) live <= 1'b0;
    else              live <= 1'b1;
  end

  wstate_t w_state, w_next;
  logic aw_hs, w_hs, b_hs, aw_bad, w_en;
  logic [MEM_AW-1:0] w_idx;
  logic [7:0] w_len;
  logic [8:0] w_cnt;
  logic w_fixed, w_err;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign b_hs   = s_axi_bvalid && s_axi_bready;
  assign aw_bad = s_axi_awburst[1] || (|s_axi_awaddr[31:MEM_AW+OFF]);
  // Beats past awlen+1 are accepted but dropped; the burst still waits for wlast.
  assign w_en   = w_hs && !w_err && (w_cnt <= {1'b0, w_len});

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && s_axi_wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = live && (w_state == W_IDLE);
    s_axi_wready  = (w_state == W_DATA);
    s_axi_bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_bid   <= '0;
      s_axi_bresp <= 2'b00;
      w_idx       <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_fixed     <= 1'b0;
      w_err       <= 1'b0;
    end else if (aw_hs) begin
      s_axi_bid <= s_axi_awid;
      w_idx     <= s_axi_awaddr[MEM_AW+OFF-1:OFF];
      w_len     <= s_axi_awlen;
      w_fixed   <= (s_axi_awburst == 2'b00);
      w_err     <= aw_bad;
      w_cnt     <= '0;
    end else if (w_hs) begin
      if (w_cnt <= {1'b0, w_len}) w_cnt <= w_cnt + 9'd1;
      if (!w_fixed) w_idx <= w_idx + 1'b1;
      if (s_axi_wlast)
        s_axi_bresp <= (w_err || (w_cnt != {1'b0, w_len})) ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_en) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  rstate_t r_state, r_next;
  logic ar_hs, r_hs, r_done, ar_bad;
  logic [MEM_AW-1:0] ar_idx, r_idx, r_idx_next;
  logic [7:0] r_len, r_cnt;
  logic r_fixed, r_err;

  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign r_hs       = s_axi_rvalid && s_axi_rready;
  assign r_done     = r_hs && (r_cnt == r_len);
  assign ar_bad     = s_axi_arburst[1] || (|s_axi_araddr[31:MEM_AW+OFF]);
  assign ar_idx     = s_axi_araddr[MEM_AW+OFF-1:OFF];
  assign r_idx_next = r_fixed ? r_idx : r_idx + 1'b1;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = live && (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  // rdata is loaded on the same edge that accepts AR or a beat, so a beat
  // written on that edge is seen with its old contents.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_rid   <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
      s_axi_rlast <= 1'b0;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_fixed     <= 1'b0;
      r_err       <= 1'b0;
    end else if (ar_hs) begin
      s_axi_rid   <= s_axi_arid;
      s_axi_rresp <= ar_bad ? 2'b10 : 2'b00;
      s_axi_rdata <= ar_bad ? '0 : mem[ar_idx];
      s_axi_rlast <= (s_axi_arlen == 8'd0);
      r_idx       <= ar_idx;
      r_len       <= s_axi_arlen;
      r_cnt       <= '0;
      r_fixed     <= (s_axi_arburst == 2'b00);
      r_err       <= ar_bad;
    end else if (r_done) begin
      s_axi_rlast <= 1'b0;
    end else if (r_hs) begin
      r_cnt       <= r_cnt + 8'd1;
      r_idx       <= r_idx_next;
      s_axi_rdata <= r_err ? '0 : mem[r_idx_next];
      s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
    end
  end
endmodule
